// File: rtl/ahb_wait_ram.sv
// AHB-Lite single-beat word memory with programmable wait states, byte-lane
// writes and a two-cycle ERROR response for illegal or out-of-range transfers.
module ahb_wait_ram #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [3:0]            HWSTRB,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [31:0]           ok_count,
  output logic [15:0]           err_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  localparam logic [2:0] WS_M1 = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q;
  logic                    hready_q;
  logic                    hresp_q;
  logic                    wr_q;
  logic [IDX_W-1:0]        idx_q;
  logic [2:0]              wcnt_q;
  logic [31:0]             ok_count_q;
  logic [15:0]             err_count_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  logic [ADDR_WIDTH:0]     offset;
  logic                    accept;
  logic                    acc_err;
  logic                    mem_we;
  logic                    unused_bits;

  // Extra MSB catches the borrow, so below-base addresses also fail the span compare.
  assign offset  = {1'b0, HADDR} - {1'b0, BASE_ADDR};
  assign accept  = HSEL && HTRANS[1] && hready_q;
  assign acc_err = (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) || (offset >= SPAN);
  assign mem_we  = (state_q == S_LAST) && wr_q;

  assign unused_bits = ^{HTRANS[0], offset[ADDR_WIDTH:IDX_W+2], offset[1:0]};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      ok_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_LAST: begin
          if (state_q == S_LAST) ok_count_q <= ok_count_q + 32'd1;
          if (accept) begin
            idx_q <= offset[IDX_W+1:2];
            wr_q  <= HWRITE;
            if (acc_err) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_q  <= S_LAST;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end else begin
              state_q  <= S_BUSY;
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
              wcnt_q   <= WS_M1;
            end
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (wcnt_q == 3'd0) begin
            state_q  <= S_LAST;
            hready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        S_ERR2: begin
          err_count_q <= err_count_q + 16'd1;
          state_q     <= S_IDLE;
          hready_q    <= 1'b1;
          hresp_q     <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; contents survive nRST.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADY    = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = ((state_q == S_LAST) && !wr_q) ? mem[idx_q] : '0;
  assign ok_count  = ok_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ahb_wait_ram.sv
// Randomized self-checking bench: three memories (0, 3 and 5 wait states)
// driven one at a time and compared against an array-based reference model.
module tb_ahb_wait_ram;

  localparam int unsigned ND    = 3;
  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] BASE  = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] nrst, hsel, hwrite, hready, hresp;
  logic [1:0]    htrans [ND];
  logic [2:0]    hsize  [ND];
  logic [31:0]   haddr  [ND];
  logic [31:0]   hwdata [ND];
  logic [3:0]    hwstrb [ND];
  logic [31:0]   hrdata [ND];
  logic [31:0]   okc    [ND];
  logic [15:0]   errc   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 3 : 5;
    ahb_wait_ram #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(W)
    ) u_dut (
      .clk      (clk),
      .nRST     (nrst[g]),
      .HSEL     (hsel[g]),
      .HTRANS   (htrans[g]),
      .HWRITE   (hwrite[g]),
      .HSIZE    (hsize[g]),
      .HADDR    (haddr[g]),
      .HWDATA   (hwdata[g]),
      .HWSTRB   (hwstrb[g]),
      .HREADY   (hready[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g]),
      .ok_count (okc[g]),
      .err_count(errc[g])
    );
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mdl [ND][DEPTH];
  int unsigned m_ok  [ND];
  int unsigned m_err [ND];

  bit          bq_wr   [$];
  logic [31:0] bq_addr [$];
  logic [31:0] bq_wd   [$];
  logic [3:0]  bq_st   [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic bit is_err(input logic [2:0] sz, input logic [31:0] addr);
    longint a = longint'(addr);
    longint b = longint'(BASE);
    return (sz != 3'b010) || (addr[1:0] != 2'b00) || (a < b) || (a >= b + DEPTH * 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    return BASE + ($urandom_range(0, DEPTH - 1) << 2);
  endfunction

  task automatic present(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a);
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; hsize[d] = sz; haddr[d] = a;
  endtask

  task automatic go_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00;
  endtask

  task automatic check_counts(input int d);
    check($sformatf("d%0d_okc", d), okc[d], m_ok[d]);
    check($sformatf("d%0d_errc", d), 32'(errc[d]), m_err[d] & 32'hFFFF);
  endtask

  // One isolated transfer; starts and ends #1 after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st);
    bit err, done, r0, r1;
    int unsigned idx, waits;
    logic [31:0] rd;
    err = is_err(sz, addr);
    idx = ((addr - BASE) >> 2) % DEPTH;
    present(d, wr, sz, addr);
    @(posedge clk); #1;
    go_idle(d);
    haddr[d] = $urandom; hwdata[d] = wd; hwstrb[d] = st;
    done = 0; waits = 0; r0 = 0; r1 = 0; rd = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (c == 0) r0 = hresp[d];
      if (hready[d]) begin
        done = 1; r1 = hresp[d]; rd = hrdata[d];
      end else begin
        waits++;
        check($sformatf("d%0d_rd_wait", d), hrdata[d], 32'h0);
      end
      @(posedge clk); #1;
    end
    check($sformatf("d%0d_done", d), 32'(done), 32'd1);
    if (err) begin
      check($sformatf("d%0d_err_waits", d), waits, 32'd1);
      check($sformatf("d%0d_err_r0", d), 32'(r0), 32'd1);
      check($sformatf("d%0d_err_r1", d), 32'(r1), 32'd1);
      check($sformatf("d%0d_err_rd", d), rd, 32'h0);
      m_err[d]++;
    end else begin
      check($sformatf("d%0d_waits", d), waits, ws_of(d));
      check($sformatf("d%0d_resp", d), 32'(r1), 32'd0);
      check($sformatf("d%0d_rdata", d), rd, wr ? 32'h0 : mdl[d][idx]);
      if (wr) mdl[d][idx] = merge(mdl[d][idx], wd, st);
      m_ok[d]++;
    end
    check_counts(d);
  endtask

  // Back-to-back legal transfers from the bq_* queues, next address in the completing cycle.
  task automatic burst(input int d);
    int n = bq_addr.size();
    int unsigned idx, waits;
    bit done;
    logic [31:0] rd;
    logic rsp;
    present(d, bq_wr[0], 3'b010, bq_addr[0]);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      hwdata[d] = bq_wd[k]; hwstrb[d] = bq_st[k];
      if (k + 1 < n) present(d, bq_wr[k+1], 3'b010, bq_addr[k+1]);
      else go_idle(d);
      done = 0; waits = 0; rd = '0; rsp = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (hready[d]) begin done = 1; rd = hrdata[d]; rsp = hresp[d]; end
        else waits++;
        @(posedge clk); #1;
      end
      idx = ((bq_addr[k] - BASE) >> 2) % DEPTH;
      check($sformatf("d%0d_b_done", d), 32'(done), 32'd1);
      check($sformatf("d%0d_b_waits", d), waits, ws_of(d));
      check($sformatf("d%0d_b_resp", d), 32'(rsp), 32'd0);
      check($sformatf("d%0d_b_rdata", d), rd, bq_wr[k] ? 32'h0 : mdl[d][idx]);
      if (bq_wr[k]) mdl[d][idx] = merge(mdl[d][idx], bq_wd[k], bq_st[k]);
      m_ok[d]++;
    end
    check_counts(d);
    bq_wr.delete(); bq_addr.delete(); bq_wd.delete(); bq_st.delete();
  endtask

  task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    bq_wr.push_back(wr); bq_addr.push_back(a); bq_wd.push_back(wd); bq_st.push_back(st);
  endtask

  task automatic run_dut(input int d);
    logic [31:0] a, line [16];
    logic [31:0] pool [4];
    logic [2:0]  sz;
    int kind;
    for (int w = 0; w < DEPTH; w++) xfer(d, 1'b1, 3'b010, BASE + 32'(w * 4), $urandom, 4'hF);
    // Basic write/read and byte-lane merge.
    xfer(d, 1'b1, 3'b010, BASE + 32'h40, 32'hDEADBEEF, 4'hF);
    xfer(d, 1'b0, 3'b010, BASE + 32'h40, 32'h0, 4'h0);
    xfer(d, 1'b1, 3'b010, BASE + 32'h44, 32'h11223344, 4'hF);
    xfer(d, 1'b1, 3'b010, BASE + 32'h44, 32'hAABBCCDD, 4'b0101);
    xfer(d, 1'b0, 3'b010, BASE + 32'h44, 32'h0, 4'h0);
    xfer(d, 1'b1, 3'b010, BASE + 32'h44, 32'h55555555, 4'h0);
    xfer(d, 1'b0, 3'b010, BASE + 32'h44, 32'h0, 4'h0);
    // Error boundaries, including an erroring write to a legal word.
    xfer(d, 1'b0, 3'b010, BASE + DEPTH * 4, 32'h0, 4'h0);
    xfer(d, 1'b0, 3'b010, BASE + DEPTH * 4 - 4, 32'h0, 4'h0);
    xfer(d, 1'b0, 3'b010, BASE - 4, 32'h0, 4'h0);
    xfer(d, 1'b0, 3'b000, BASE + 32'h40, 32'h0, 4'h0);
    xfer(d, 1'b1, 3'b010, BASE + 32'h42, 32'h12345678, 4'hF);
    xfer(d, 1'b1, 3'b001, BASE + 32'h40, 32'h12345678, 4'hF);
    xfer(d, 1'b0, 3'b010, BASE + 32'h40, 32'h0, 4'h0);
    xfer(d, 1'b0, 3'b010, BASE, 32'h0, 4'h0);
    // 16-beat line write then read at offset 0x100.
    for (int i = 0; i < 16; i++) begin
      line[i] = $urandom;
      push(1'b1, BASE + 32'h100 + 32'(i * 4), line[i], 4'hF);
    end
    burst(d);
    for (int i = 0; i < 16; i++) push(1'b0, BASE + 32'h100 + 32'(i * 4), 32'h0, 4'h0);
    burst(d);
    for (int i = 0; i < 16; i++)
      check($sformatf("d%0d_line", d), mdl[d][64 + i], line[i]);
    // Random singles with occasional illegal transfers.
    for (int t = 0; t < 40; t++) begin
      a = rand_addr(); sz = 3'b010;
      kind = $urandom_range(0, 9);
      if (kind == 0) sz = 3'($urandom_range(0, 7));
      else if (kind == 1) a = a | 32'($urandom_range(1, 3));
      else if (kind == 2) a = BASE + DEPTH * 4 + ($urandom_range(0, 255) << 2);
      else if (kind == 3) a = BASE - 4 - ($urandom_range(0, 255) << 2);
      xfer(d, 1'($urandom), sz, a, $urandom, 4'($urandom));
    end
    // Random pipelined bursts over a small address pool to hit read-after-write.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) pool[i] = rand_addr();
      for (int i = 0; i < 10; i++)
        push(1'($urandom), pool[$urandom_range(0, 3)], $urandom, 4'($urandom));
      burst(d);
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b1, BASE + 32'h80, $urandom, 4'($urandom));
      push(1'b0, BASE + 32'h80, 32'h0, 4'h0);
    end
    burst(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst = '0; hsel = '0; hwrite = '0;
    for (int d = 0; d < ND; d++) begin
      htrans[d] = 2'b00; hsize[d] = 3'b010; haddr[d] = '0; hwdata[d] = '0; hwstrb[d] = '0;
      m_ok[d] = 0; m_err[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_rst_hready", d), 32'(hready[d]), 32'd1);
      check($sformatf("d%0d_rst_hresp", d), 32'(hresp[d]), 32'd0);
      check($sformatf("d%0d_rst_rdata", d), hrdata[d], 32'h0);
      check_counts(d);
    end
    @(negedge clk);
    nrst = '1;
    @(posedge clk); #1;

    for (int d = 0; d < ND; d++) run_dut(d);

    // Reset asserted while a 5-wait-state write is still in its BUSY phase.
    present(2, 1'b1, 3'b010, BASE + 32'h80);
    @(posedge clk); #1;
    go_idle(2);
    hwdata[2] = ~mdl[2][32]; hwstrb[2] = 4'hF;
    @(posedge clk); #2;
    nrst[2] = 1'b0;
    #1;
    m_ok[2] = 0; m_err[2] = 0;
    check("rst_mid_hready", 32'(hready[2]), 32'd1);
    check("rst_mid_hresp", 32'(hresp[2]), 32'd0);
    check("rst_mid_rdata", hrdata[2], 32'h0);
    check_counts(2);
    @(negedge clk);
    nrst[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 3'b010, BASE + 32'h80, 32'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_wait_ram.md
Name: ahb_wait_ram

Overview:
AHB-Lite subordinate word memory that sits directly downstream of the Vortex-to-AHB adapter in the testbench. It consumes the adapter's single-beat 32-bit NONSEQ transfers: reads return HRDATA, writes apply HWSTRB byte lanes. Response latency is programmable through wait states, and unsupported or out-of-range transfers get a two-cycle ERROR response. The block lets the adapter's 16-beat line fills and evictions be exercised under realistic subordinate timing.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, bus width; only 32 is supported.
DEPTH_WORDS, 4096, number of 32-bit words; power of two.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
WAIT_STATES, 0, HREADY-low cycles per data phase; legal range 0..7.

Ports:
clk  in  1  clock; all logic is on the rising edge.
nRST  in  1  asynchronous, active-low reset.
HSEL  in  1  subordinate select.
HTRANS  in  2  transfer type; bit 1 set means NONSEQ or SEQ, which are treated the same.
HWRITE  in  1  1 = write.
HSIZE  in  3  transfer size; only 3'b010 is legal.
HADDR  in  ADDR_WIDTH  byte address.
HWDATA  in  DATA_WIDTH  write data, sampled in the completing data-phase cycle.
HWSTRB  in  4  byte-lane write enables, sampled with HWDATA.
HREADY  out  1  data-phase complete; single-manager system, so this also serves as the address-phase qualifier.
HRESP  out  1  1 = ERROR.
HRDATA  out  DATA_WIDTH  read data.
ok_count  out  32  count of OKAY completions.
err_count  out  16  count of ERROR responses.

Behaviour:
- Reset (async, nRST low):
  - state = IDLE; HREADY = 1; HRESP = 0; HRDATA = 0; ok_count = 0; err_count = 0; wait counter = 0.
  - Memory contents are not cleared.
- Accept:
  - A transfer is accepted on a rising edge where HSEL && HTRANS[1] && HREADY.
  - On accept, capture word index (HADDR-BASE_ADDR)>>2 and HWRITE.
  - Error check on accept: HSIZE != 3'b010, HADDR[1:0] != 0, HADDR < BASE_ADDR, or HADDR >= BASE_ADDR + DEPTH_WORDS*4.
- States:
  - IDLE: HREADY=1, HRESP=0. Accept with error -> ERR1. Accept with WAIT_STATES==0 -> LAST. Accept otherwise -> BUSY with counter=WAIT_STATES-1.
  - BUSY: HREADY=0, HRESP=0. Counter==0 -> LAST; else decrement. Address inputs are ignored.
  - LAST: HREADY=1, HRESP=0; this is the completing cycle.
    - Read: HRDATA = mem[captured index] (combinational).
    - Write: at this clock edge, mem bytes with HWSTRB[i]=1 take HWDATA[8i+7:8i]; other bytes are unchanged.
    - ok_count += 1.
    - A new accept in the same cycle is pipelined: next state chosen as in IDLE. No accept -> IDLE.
  - ERR1: HREADY=0, HRESP=1 -> ERR2.
  - ERR2: HREADY=1, HRESP=1; err_count += 1 -> IDLE.
    - An address phase presented in ERR2 is ignored (the manager is required to cancel after an error).
    - Memory is never modified by an erroring transfer.
- HRDATA is 0 in every cycle other than a read LAST cycle.
- Throughput: with WAIT_STATES=0, back-to-back transfers complete one per cycle. Otherwise one per WAIT_STATES+1 cycles.
- Read-after-write: a read whose address phase coincides with the LAST cycle of a write to the same word returns the new data.
- HWSTRB=0 on a write: OKAY completion, no memory change, ok_count increments.
- Counter wrap: ok_count and err_count wrap modulo 2^width silently.
- Reset mid-transfer: an in-flight data phase is abandoned; no partial write occurs; outputs return to reset values immediately.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF with HWSTRB=4'hF to 0x40, then read 0x40 -> HRDATA=0xDEADBEEF in the read LAST cycle; ok_count=2.
2. Byte merge: word holds 0x11223344; write 0xAABBCCDD with HWSTRB=4'b0101 -> read returns 0x11BB33DD.
3. WAIT_STATES=3: single read -> HREADY low for exactly 3 cycles after the accept edge, high on the 4th with data; repeated back-to-back, one completion every 4 cycles.
4. Drive with the adapter: 16-beat write of a 64-byte line at 0x100, then 16-beat read -> mem_rsp_data equals the written 512 bits; ok_count=32; HRESP never asserted.
5. Read at BASE_ADDR + DEPTH_WORDS*4, and separately a read with HSIZE=3'b000 -> each gives HRESP=1/HREADY=0 then HRESP=1/HREADY=1; err_count=2; memory unchanged.
6. WAIT_STATES=5: assert nRST low during BUSY of a write to 0x80 -> HREADY=1 and HRESP=0 at once; a later read of 0x80 returns the prior contents.
